// File: rtl/sigmacore_pkg.sv
// Shared types and widths for the SigmaCore writeback stage.
package sigmacore_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_aligner.sv
// Combinational load lane select, sign/zero extension and misalignment detect.
// Size encoding 3 is not a legal load size and is treated like a word.
module load_aligner
  import sigmacore_pkg::*;
#(
  parameter int XLEN = sigmacore_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sign_bit;

  always_comb begin
    byte_lane    = raw_i[8*offset_i +: 8];
    half_lane    = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
    sign_bit     = 1'b0;
    data_o       = raw_i;
    misaligned_o = 1'b0;
    case (mem_size_e'(size_i))
      SZ_BYTE: begin
        sign_bit = ~unsigned_i & byte_lane[7];
        data_o   = {{(XLEN-8){sign_bit}}, byte_lane};
      end
      SZ_HALF: begin
        sign_bit     = ~unsigned_i & half_lane[15];
        data_o       = {{(XLEN-16){sign_bit}}, half_lane};
        misaligned_o = offset_i[0];
      end
      default: begin
        data_o       = raw_i;
        misaligned_o = (offset_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// SigmaCore writeback: load wait/alignment, register-file write port, instret.
// Optional decode bypass mirror enabled by SIGMACORE_WB_BYPASS_EN.
module writeback_stage
  import sigmacore_pkg::*;
#(
  parameter int XLEN  = sigmacore_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd_addr,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [1:0]       in_mem_size,
  input  logic             in_mem_unsigned,
  input  logic [1:0]       in_byte_offset,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  output logic [4:0]       rf_write_addr,
  output logic [XLEN-1:0]  rf_write_data,
  output logic             rf_write_enable,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret,
  output logic             byp_valid,
  output logic [4:0]       byp_addr,
  output logic [XLEN-1:0]  byp_data
);

  wb_state_e        state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d;
  logic             mis_q, mis_d;
  logic [4:0]       addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  ld_data;
  logic             ld_mis;
  wb_sel_e          sel_in;

  load_aligner #(.XLEN(XLEN)) u_aligner (
    .raw_i        (mem_rsp_data),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .offset_i     (off_q),
    .data_o       (ld_data),
    .misaligned_o (ld_mis)
  );

  assign in_ready = (state_q != WAIT_MEM);
  assign sel_in   = wb_sel_e'(in_wb_sel);

  // Non-loads register their write at the accept edge so the write port is
  // live in the very next cycle; loads do the same at the response edge.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    we_d      = 1'b0;
    mis_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    instret_d = instret_q;
    case (state_q)
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          state_d = WRITE;
          addr_d  = rd_q;
          data_d  = ld_data;
          mis_d   = ld_mis;
          we_d    = ~ld_mis && (rd_q != 5'd0);
          if (!ld_mis) instret_d = instret_q + CNT_W'(1);
        end
      end
      default: begin
        if (in_valid) begin
          rd_d   = in_rd_addr;
          size_d = in_mem_size;
          uns_d  = in_mem_unsigned;
          off_d  = in_byte_offset;
          if (sel_in == WB_MEM) begin
            state_d = WAIT_MEM;
          end else begin
            state_d   = WRITE;
            addr_d    = in_rd_addr;
            data_d    = (sel_in == WB_PC4) ? in_pc_plus4 : in_alu_result;
            we_d      = (in_rd_addr != 5'd0) && (sel_in != WB_NONE);
            instret_d = instret_q + CNT_W'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      instret_q <= instret_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = addr_q;
  assign rf_write_data   = data_q;
  assign misalign_err    = mis_q;
  assign instret         = instret_q;

`ifdef SIGMACORE_WB_BYPASS_EN
  assign byp_valid = we_q;
  assign byp_addr  = addr_q;
  assign byp_data  = data_q;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule
